// File: rtl/fetch_queue.sv
//==============================================================================
// Module  : fetch_queue
// Brief   : Instruction fetch queue owning the fetch PC, one outstanding ibus
//           request and a DEPTH-entry buffer of {pc, instr, misalign}.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output ibus_req_t                  ireq,
    input  ibus_resp_t                 iresp,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_misalign,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [63:0]          r_fetch_pc;
    logic [63:0]          r_req_pc;
    logic                 r_halted;
    logic [63:0]          r_mem_pc    [DEPTH];
    logic [31:0]          r_mem_instr [DEPTH];
    logic                 r_mem_mis   [DEPTH];

    logic                 w_pop;
    logic                 w_resp_push;
    logic [63:0]          w_launch_pc;
    logic                 w_launch_mis;
    logic [c_CNT_W:0]     w_count_base;
    logic                 w_space;
    logic                 w_try_launch;
    logic                 w_mis_push;
    logic                 w_new_req;
    logic                 w_chain;
    logic                 w_push;
    logic [c_PTR_W-1:0]   w_wr_idx;
    logic [63:0]          w_wr_pc;
    logic [31:0]          w_wr_instr;

    assign w_pop        = out_valid & out_ready & ~redirect_valid;
    assign w_resp_push  = (r_state == S_REQ) & iresp.data_ok & ~redirect_valid;
    assign w_launch_pc  = redirect_valid ? redirect_pc : r_fetch_pc;
    assign w_launch_mis = (w_launch_pc[1:0] != 2'b00);

    // Occupancy after this cycle's flush, pop and response push.
    always_comb begin
        w_count_base = '0;
        if (!redirect_valid) begin
            w_count_base = {1'b0, r_count}
                         + {{c_CNT_W{1'b0}}, w_resp_push}
                         - {{c_CNT_W{1'b0}}, w_pop};
        end
    end

    assign w_space = (w_count_base < c_DEPTH);

    // Cycles in which the launch rule is evaluated against w_launch_pc; a
    // halted fetch only resumes through a redirect.
    assign w_try_launch = ((r_state == S_IDLE) & (~r_halted | redirect_valid))
                        | ((r_state == S_REQ)  & iresp.data_ok & redirect_valid)
                        | ((r_state == S_DROP) & iresp.data_ok);

    assign w_mis_push = w_try_launch & w_launch_mis & w_space;
    assign w_new_req  = w_try_launch & ~w_launch_mis & fetch_en & w_space;
    assign w_chain    = w_resp_push & fetch_en & w_space;
    assign w_push     = w_resp_push | w_mis_push;

    assign w_wr_idx   = redirect_valid ? '0 : r_tail;
    assign w_wr_pc    = w_resp_push ? r_req_pc : w_launch_pc;
    assign w_wr_instr = w_resp_push ? iresp.data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_halted   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
                r_mem_mis[i]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_pc[w_wr_idx]    <= w_wr_pc;
                r_mem_instr[w_wr_idx] <= w_wr_instr;
                r_mem_mis[w_wr_idx]   <= ~w_resp_push;
            end

            r_head  <= redirect_valid ? '0 : r_head + c_PTR_W'(w_pop);
            r_tail  <= w_wr_idx + c_PTR_W'(w_push);
            r_count <= c_CNT_W'(w_count_base + {{c_CNT_W{1'b0}}, w_mis_push});

            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_resp_push) begin
                r_fetch_pc <= r_req_pc + 64'd4;
            end

            if (w_new_req) begin
                r_req_pc <= w_launch_pc;
            end else if (w_chain) begin
                r_req_pc <= r_req_pc + 64'd4;
            end

            if (w_mis_push) begin
                r_halted <= 1'b1;
            end else if (redirect_valid) begin
                r_halted <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_new_req) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (iresp.data_ok) begin
                        r_state <= (w_new_req || w_chain) ? S_REQ : S_IDLE;
                    end else if (redirect_valid) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (iresp.data_ok) begin
                        r_state <= w_new_req ? S_REQ : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ireq.valid = (r_state != S_IDLE);
    assign ireq.addr  = r_req_pc;
    assign ireq.size  = 3'd0;

    assign out_valid    = (r_count != '0);
    assign out_pc       = r_mem_pc[r_head];
    assign out_instr    = r_mem_instr[r_head];
    assign out_misalign = r_mem_mis[r_head];
    assign count        = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//==============================================================================
// Module  : tb_fetch_queue
// Brief   : Self-checking bench for fetch_queue against a transaction-level
//           queue model with a variable-latency instruction memory.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic        out_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign),
        .out_ready      (out_ready),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO of entries plus one outstanding-request record.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    logic        m_busy;
    logic        m_drop;
    logic [63:0] m_addr;
    logic [63:0] m_pc;
    logic        m_halt;
    int          lat_left;
    int          lat_min = 0;
    int          lat_max = 0;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_addr   = 64'd0;
        m_pc     = RST_PC;
        m_halt   = 1'b0;
        lat_left = 0;
    endtask

    task automatic model_step(input logic redir, input logic [63:0] rpc, input logic fe,
                              input logic ordy, input logic dok, input logic [31:0] d);
        ent_t e;
        if (redir) mq.delete();
        else if (mq.size() != 0 && ordy) void'(mq.pop_front());
        if (m_busy && dok && !m_drop && !redir) begin
            e.pc = m_addr; e.instr = d; e.mis = 1'b0;
            mq.push_back(e);
            m_pc = m_addr + 64'd4;
        end
        if (redir) begin
            m_pc   = rpc;
            m_halt = 1'b0;
        end
        if (m_busy && dok) m_busy = 1'b0;
        else if (m_busy && redir) m_drop = 1'b1;
        if (!m_busy && !m_halt && mq.size() < DEPTH) begin
            if (m_pc[1:0] != 2'b00) begin
                e.pc = m_pc; e.instr = 32'd0; e.mis = 1'b1;
                mq.push_back(e);
                m_halt = 1'b1;
            end else if (fe) begin
                m_busy = 1'b1;
                m_drop = 1'b0;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic check_outputs();
        check("ireq.valid", 64'(ireq.valid), 64'(m_busy));
        if (m_busy) check("ireq.addr", ireq.addr, m_addr);
        check("count", 64'(count), 64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", 64'(out_instr), 64'(mq[0].instr));
            check("out_misalign", 64'(out_misalign), 64'(mq[0].mis));
        end
    endtask

    // One clock: check, drive, advance model, then step to posedge+1.
    task automatic cycle(input logic redir, input logic [63:0] rpc, input logic fe, input logic ordy);
        logic dok;
        logic was_busy;
        check_outputs();
        dok = m_busy && (lat_left == 0);
        redirect_valid = redir;
        redirect_pc    = rpc;
        fetch_en       = fe;
        out_ready      = ordy;
        iresp.data_ok  = dok;
        iresp.data     = dok ? mem_data(m_addr) : 32'($urandom);
        was_busy = m_busy;
        model_step(redir, rpc, fe, ordy, dok, iresp.data);
        if (m_busy && (!was_busy || dok)) lat_left = $urandom_range(lat_max, lat_min);
        else if (m_busy) lat_left--;
        @(posedge clk);
        #1;
    endtask

    // Reset with a stray data_ok pending; it must be ignored.
    task automatic do_reset();
        reset          = 1'b1;
        iresp.data_ok  = 1'b1;
        iresp.data     = 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst.ireq_valid", 64'(ireq.valid), 64'd0);
        check("rst.count", 64'(count), 64'd0);
        reset         = 1'b0;
        iresp.data_ok = 1'b0;
        m_reset();
    endtask

    task automatic run_until_req(input logic [63:0] a, input logic ordy);
        int k = 0;
        while (!(m_busy && !m_drop && m_addr == a) && k < 40) begin
            cycle(1'b0, 64'd0, 1'b1, ordy);
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_fail++;
            $error("FAIL timeout: no request to %h", a);
        end
    endtask

    initial begin
        logic        r_redir;
        logic [63:0] r_pc;
        reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b0; iresp = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.ireq_valid", 64'(ireq.valid), 64'd0);
        check("reset.ireq_addr", ireq.addr, 64'd0);
        check("reset.count", 64'(count), 64'd0);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_pc", out_pc, 64'd0);
        check("reset.out_instr", 64'(out_instr), 64'd0);
        check("reset.out_misalign", 64'(out_misalign), 64'd0);
        reset = 1'b0;

        // Zero-wait streaming at one instruction per cycle.
        lat_min = 0; lat_max = 0;
        cycle(1'b0, 64'd0, 1'b1, 1'b1);
        check("first.ireq_valid", 64'(ireq.valid), 64'd1);
        check("first.ireq_addr", ireq.addr, 64'h8000_0000);
        cycle(1'b0, 64'd0, 1'b1, 1'b1);
        check("stream.pc0", out_pc, 64'h8000_0000);
        cycle(1'b0, 64'd0, 1'b1, 1'b1);
        check("stream.pc1", out_pc, 64'h8000_0004);
        cycle(1'b0, 64'd0, 1'b1, 1'b1);
        check("stream.pc2", out_pc, 64'h8000_0008);

        // Fill to DEPTH with the consumer stalled, then release one pop.
        do_reset();
        repeat (10) cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check("full.count", 64'(count), 64'd4);
        check("full.ireq_valid", 64'(ireq.valid), 64'd0);
        cycle(1'b0, 64'd0, 1'b1, 1'b1);
        check("refill.ireq_valid", 64'(ireq.valid), 64'd1);
        check("refill.ireq_addr", ireq.addr, 64'h8000_0010);

        // Redirect while a delayed response is outstanding.
        do_reset();
        lat_min = 3; lat_max = 3;
        run_until_req(64'h8000_0008, 1'b1);
        cycle(1'b1, 64'h8000_1000, 1'b1, 1'b1);
        check("drop.ireq_valid", 64'(ireq.valid), 64'd1);
        check("drop.ireq_addr", ireq.addr, 64'h8000_0008);
        check("drop.count", 64'(count), 64'd0);
        run_until_req(64'h8000_1000, 1'b1);
        check("drop.relaunch_addr", ireq.addr, 64'h8000_1000);
        check("drop.relaunch_count", 64'(count), 64'd0);

        // Redirect coinciding with data_ok and a pop, two entries queued.
        do_reset();
        lat_min = 0; lat_max = 0;
        repeat (3) cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check("coinc.pre_count", 64'(count), 64'd2);
        cycle(1'b1, 64'h8000_2000, 1'b1, 1'b1);
        check("coinc.count", 64'(count), 64'd0);
        check("coinc.ireq_addr", ireq.addr, 64'h8000_2000);

        // Misaligned redirect halts fetch until the next redirect.
        cycle(1'b1, 64'h8000_0102, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check("mis.count", 64'(count), 64'd1);
        check("mis.out_pc", out_pc, 64'h8000_0102);
        check("mis.out_misalign", 64'(out_misalign), 64'd1);
        check("mis.out_instr", 64'(out_instr), 64'd0);
        check("mis.ireq_valid", 64'(ireq.valid), 64'd0);
        lat_min = 2; lat_max = 2;
        cycle(1'b1, 64'h8000_0200, 1'b1, 1'b0);
        check("mis.resume_addr", ireq.addr, 64'h8000_0200);

        // fetch_en dropped with a request outstanding.
        repeat (5) cycle(1'b0, 64'd0, 1'b0, 1'b0);
        check("fen.ireq_valid", 64'(ireq.valid), 64'd0);
        check("fen.count", 64'(count), 64'd1);
        check("fen.out_instr", 64'(out_instr), 64'(mem_data(64'h8000_0200)));
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check("fen.resume_addr", ireq.addr, 64'h8000_0204);

        // Randomized traffic including PC wrap and occasional resets.
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                r_redir = ($urandom_range(19, 0) == 0);
                case ($urandom_range(7, 0))
                    0: r_pc = 64'hFFFF_FFFF_FFFF_FFF8;
                    1: r_pc = 64'h8000_0000 + 64'($urandom_range(255, 0) * 4 + $urandom_range(3, 1));
                    default: r_pc = 64'h8000_0000 + 64'($urandom_range(255, 0) * 4);
                endcase
                cycle(r_redir, r_pc, $urandom_range(9, 0) != 0, $urandom_range(9, 0) < 7);
            end
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue that decouples the ibus from the decode stage of the pipelined core. It owns the fetch PC, issues at most one outstanding ibus request, buffers up to DEPTH fetched instructions with their PCs, and discards in-flight responses on redirect (branch, CSR write, exception, MRET). It replaces the PC register, PC stall logic and IF/ID register path, so ibus latency no longer stalls decode directly.

## Interface

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2
- RESET_PC, 64'h8000_0000, fetch PC after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ireq  out  ibus_req_t  fields used: valid, addr (64); other fields 0
- iresp  in  ibus_resp_t  fields used: data_ok, data[31:0]
- fetch_en  in  1  permits new ibus requests; low during exception drain
- redirect_valid  in  1  flush the queue and restart fetch
- redirect_pc  in  64  new fetch PC
- out_valid  out  1  head entry valid
- out_pc  out  64  head entry PC
- out_instr  out  32  head entry instruction (0 when misaligned)
- out_misalign  out  1  head entry PC has bits [1:0] != 0
- out_ready  in  1  consumer pops the head when out_valid is high
- count  out  $clog2(DEPTH+1)  occupied entries

Clocking: one clock; reset is synchronous and active-high.

## Operation

- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH. Registers: count, fetch_pc, req_pc, state.
- States:
  - IDLE: ireq.valid=0.
  - REQ: ireq.valid=1, ireq.addr=req_pc.
  - DROP: ireq.valid=1, ireq.addr=req_pc; the response is discarded.
- ireq.addr is held stable from the first valid cycle until data_ok, including in DROP. A request is never withdrawn.
- pop = out_valid & out_ready & ~redirect_valid.
- push = REQ & data_ok & ~redirect_valid.
- count_next = count + push - pop.
- space = count_next < DEPTH.
- Launch PC L: redirect_pc when redirect_valid, else fetch_pc.
- IDLE:
  - If L[1:0] != 0 and the queue is not full after the flush/pop: push {L, instr 0, misalign 1}; no ibus request; fetch halts (stay IDLE, fetch_pc frozen) until the next redirect.
  - Otherwise, if fetch_en & space: req_pc <= L, go to REQ.
- REQ with data_ok and no redirect:
  - Push {req_pc, data, 0}; fetch_pc <= req_pc+4.
  - If fetch_en & space: stay in REQ with req_pc <= req_pc+4 (back-to-back). Else go to IDLE.
- REQ without data_ok: hold.
- Redirect (highest priority):
  - Queue empties (count=0, head=tail=0); the pop that cycle is ignored; fetch_pc <= redirect_pc.
  - REQ without data_ok: go to DROP.
  - REQ with data_ok: drop the response, then relaunch to redirect_pc the same cycle per the IDLE rule.
  - DROP: stay in DROP with the new fetch_pc.
  - IDLE: launch per the IDLE rule.
- DROP with data_ok: discard, then launch from fetch_pc per the IDLE rule.
- fetch_en low: an outstanding request completes and is pushed normally; no new request is issued.
- PC arithmetic: 64-bit, wraps modulo 2^64.

## Timing

- Reset values: state IDLE, ireq.valid 0, ireq.addr 0, count 0, head/tail 0, fetch_pc RESET_PC, out_valid 0, out_pc 0, out_instr 0, out_misalign 0.
- Outputs out_* come combinationally from head storage; out_valid = (count != 0).
- First request: ireq.valid rises the cycle after reset deasserts if fetch_en=1.
- Redirect at cycle t (state IDLE or REQ+data_ok): ireq.valid with addr=redirect_pc at t+1.
- Response data_ok at cycle t: entry visible on out_* at t+1.
- Zero-wait memory and out_ready=1: sustains 1 instruction per cycle.
- A full queue issues no request. An empty slot is always reserved for the one outstanding response, so data_ok never arrives while full.
- Reset mid-request: the block returns to IDLE and the response is ignored.

## Test plan

- Reset, fetch_en=1, zero-wait memory: ireq.valid=0 and count=0 during reset; next cycle ireq.addr=0x8000_0000; out_pc sequence 0x8000_0000, _0004, _0008 on consecutive cycles.
- DEPTH=4, out_ready=0: count reaches 4, ireq.valid drops and no 5th request is issued; raise out_ready, then the request for 0x8000_0010 issues the cycle after the first pop.
- Request to 0x8000_0008 with data_ok delayed 3 cycles; redirect to 0x8000_1000 during the wait: state DROP, ireq.addr stays 0x8000_0008, response discarded, count=0, next ireq.addr=0x8000_1000.
- Redirect coinciding with data_ok and out_ready on a 2-entry queue: count=0 the next cycle, response dropped, ireq.addr=redirect_pc.
- Redirect to 0x8000_0102: no ibus request; one entry pc=0x8000_0102, misalign=1, instr=0; fetching stays halted until a redirect to 0x8000_0200.
- fetch_en dropped while a request is outstanding: that response is still pushed and no further request is issued until fetch_en returns.
